// File: rtl/pipe_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package : pipe_pkg
// Shared types and constants for the ID-stage hazard/forwarding unit.
// Revision: 1.0
// ============================================================================
package pipe_pkg;

    localparam int REG_W    = 5;
    // Table fields are sized for the widest configuration the unit supports.
    localparam int HZ_RD_W  = 8;
    localparam int HZ_RDY_W = 4;

    // Forwarding-select encoding: 0 reads the register file, k reads slot k-1.
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic [HZ_RD_W-1:0]  rd;
        logic [HZ_RDY_W-1:0] rdy;
    } hz_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_unit_md_tracker.sv
`default_nettype none
// ============================================================================
// Module  : md_tracker
// Occupancy counter and destination register of the multi-cycle mul/div unit.
// Revision: 1.0
// ============================================================================
module md_tracker #(
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int MD_LAT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [REG_W-1:0] rd_in,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] rd
);

    localparam int            CW  = $clog2(MD_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MD_LAT);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0]    cnt_d, cnt_q;
    logic             done_d, done_q;
    logic [REG_W-1:0] rd_d, rd_q;

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        if (start) begin
            cnt_d = LAT;
            rd_d  = rd_in;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
        // done is high during the last busy cycle, i.e. while the count is 1.
        done_d = (cnt_d == ONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            rd_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            rd_q   <= rd_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = done_q;
    assign rd   = rd_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_unit
// ID-stage hazard detection, operand forwarding selects and stall control.
// Revision: 1.0
// ============================================================================
module pipe_hazard_unit #(
    parameter int  NSRC     = 2,
    parameter int  REG_W    = pipe_pkg::REG_W,
    parameter int  DEPTH    = 3,
    parameter int  LOAD_RDY = 1,
    parameter int  MD_LAT   = 4,
    localparam int FW       = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NSRC*REG_W-1:0] id_src,
    input  logic [NSRC-1:0]       id_src_used,
    input  logic                  id_wreg,
    input  logic [REG_W-1:0]      id_rd,
    input  logic                  id_load,
    input  logic                  id_md,
    input  logic                  id_valid,
    input  logic                  id_flush,
    output logic                  wpcir,
    output logic                  issue,
    output logic [NSRC*FW-1:0]    fwd_sel,
    output logic                  md_busy,
    output logic                  md_done,
    output logic [REG_W-1:0]      md_rd
);

    import pipe_pkg::*;

    hz_entry_t              w_slot0;
    hz_entry_t [DEPTH-1:0]  w_tbl;
    logic      [NSRC-1:0]   w_src_stall;
    logic                   w_md_waw;
    logic                   w_md_struct;
    logic                   w_any_stall;
    logic                   w_issue;

    // ------------------------------------------------------------------
    // In-flight write table: slot 0 = EXE, shifting one slot per cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_slot0       = '0;
        w_slot0.valid = w_issue & id_wreg & ~id_md & (id_rd != '0);
        w_slot0.rd    = HZ_RD_W'(id_rd);
        w_slot0.rdy   = id_load ? HZ_RDY_W'(LOAD_RDY) : '0;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        hz_entry_t ent_d;
        hz_entry_t ent_q;

        if (i == 0) begin : g_head
            always_comb ent_d = w_slot0;
        end else begin : g_tail
            always_comb ent_d = w_tbl[i-1];
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) ent_q <= '0;
            else       ent_q <= ent_d;
        end

        assign w_tbl[i] = ent_q;
    end

    // ------------------------------------------------------------------
    // Per-operand youngest-match search and stall detection.
    // ------------------------------------------------------------------
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [REG_W-1:0] src;
        logic [FW-1:0]    sel;
        logic             hit;
        logic             data_stall;
        logic             md_hit;

        assign src = id_src[s*REG_W +: REG_W];

        always_comb begin
            sel        = FW'(FWD_RF);
            hit        = 1'b0;
            data_stall = 1'b0;
            if (id_src_used[s] && (src != '0)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!hit && w_tbl[i].valid && (w_tbl[i].rd == HZ_RD_W'(src))) begin
                        hit = 1'b1;
                        // Producer has not reached the slot where its result exists.
                        if (HZ_RDY_W'(i) < w_tbl[i].rdy) data_stall = 1'b1;
                        else                             sel        = FW'(i + 1);
                    end
                end
            end
        end

        assign md_hit = md_busy & id_src_used[s] & (src != '0) & (src == md_rd);

        assign w_src_stall[s]       = data_stall | md_hit;
        assign fwd_sel[s*FW +: FW]  = sel;
    end

    // A new mul/div may follow in the done cycle; the unit frees up at that edge.
    assign w_md_waw    = md_busy & id_wreg & (id_rd == md_rd);
    assign w_md_struct = md_busy & id_md & ~md_done;
    assign w_any_stall = (|w_src_stall) | w_md_waw | w_md_struct;

    assign wpcir   = ~w_any_stall | id_flush;
    assign w_issue = id_valid & wpcir & ~id_flush;
    assign issue   = w_issue;

    md_tracker #(
        .REG_W  (REG_W),
        .MD_LAT (MD_LAT)
    ) u_md_tracker (
        .clock (clock),
        .reset (reset),
        .start (w_issue & id_md),
        .rd_in (id_rd),
        .busy  (md_busy),
        .done  (md_done),
        .rd    (md_rd)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_unit
// Directed and random checks of pipe_hazard_unit against a history-based model.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_unit;

    localparam int NSRC     = 2;
    localparam int REG_W    = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_RDY = 1;
    localparam int MD_LAT   = 4;
    localparam int FW       = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NSRC*REG_W-1:0] id_src;
    logic [NSRC-1:0]       id_src_used;
    logic                  id_wreg;
    logic [REG_W-1:0]      id_rd;
    logic                  id_load;
    logic                  id_md;
    logic                  id_valid;
    logic                  id_flush;
    logic                  wpcir;
    logic                  issue;
    logic [NSRC*FW-1:0]    fwd_sel;
    logic                  md_busy;
    logic                  md_done;
    logic [REG_W-1:0]      md_rd;

    pipe_hazard_unit #(
        .NSRC     (NSRC),
        .REG_W    (REG_W),
        .DEPTH    (DEPTH),
        .LOAD_RDY (LOAD_RDY),
        .MD_LAT   (MD_LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_wreg     (id_wreg),
        .id_rd       (id_rd),
        .id_load     (id_load),
        .id_md       (id_md),
        .id_valid    (id_valid),
        .id_flush    (id_flush),
        .wpcir       (wpcir),
        .issue       (issue),
        .fwd_sel     (fwd_sel),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .md_rd       (md_rd)
    );

    always #5 clock = ~clock;

    // Model: history of what issued in each past cycle (front = last cycle),
    // plus the cycle number of the last accepted mul/div.
    typedef struct {
        bit wr;
        int rd;
        bit ld;
    } rec_t;

    rec_t hist[$];
    int   cyc;
    int   md_start;
    int   md_rd_m;
    int   n_cmp;
    int   n_bad;

    logic               o_wpcir, o_issue, o_busy, o_done;
    logic [NSRC*FW-1:0] o_fwd;
    logic [REG_W-1:0]   o_mdrd;
    bit                 e_issue;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        md_start = -1000;
        md_rd_m  = 0;
    endtask

    task automatic set_in(input int s0, input int s1, input logic [1:0] used,
                          input logic wreg, input int rd, input logic ld,
                          input logic md, input logic valid, input logic flush);
        id_src      = {REG_W'(s1), REG_W'(s0)};
        id_src_used = used;
        id_wreg     = wreg;
        id_rd       = REG_W'(rd);
        id_load     = ld;
        id_md       = md;
        id_valid    = valid;
        id_flush    = flush;
    endtask

    task automatic check_outputs();
        bit                 stall;
        bit                 busy;
        bit                 done;
        bit                 e_wpcir;
        int                 el;
        int                 fsel;
        int                 src;
        int                 need;
        logic [NSRC*FW-1:0] e_fwd;

        el    = cyc - md_start;
        busy  = !reset && (el >= 1) && (el <= MD_LAT);
        done  = busy && (el == MD_LAT);
        stall = 1'b0;
        e_fwd = '0;
        for (int s = 0; s < NSRC; s++) begin
            src  = int'(id_src[s*REG_W +: REG_W]);
            fsel = 0;
            if (id_src_used[s] && src != 0) begin
                for (int i = 0; i < hist.size(); i++) begin
                    if (hist[i].wr && hist[i].rd == src) begin
                        need = hist[i].ld ? LOAD_RDY : 0;
                        if (i < need) stall = 1'b1;
                        else          fsel  = i + 1;
                        break;
                    end
                end
                if (busy && src == md_rd_m) stall = 1'b1;
            end
            e_fwd[s*FW +: FW] = FW'(fsel);
        end
        if (busy && id_wreg && int'(id_rd) == md_rd_m) stall = 1'b1;
        if (busy && id_md && !done) stall = 1'b1;
        e_wpcir = !stall || id_flush;
        e_issue = id_valid && e_wpcir && !id_flush;

        o_wpcir = wpcir;
        o_issue = issue;
        o_fwd   = fwd_sel;
        o_busy  = md_busy;
        o_done  = md_done;
        o_mdrd  = md_rd;

        chk("wpcir",   32'(wpcir),   32'(e_wpcir));
        chk("issue",   32'(issue),   32'(e_issue));
        chk("fwd_sel", 32'(fwd_sel), 32'(e_fwd));
        chk("md_busy", 32'(md_busy), 32'(busy));
        chk("md_done", 32'(md_done), 32'(done));
        chk("md_rd",   32'(md_rd),   32'(md_rd_m));
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        rec_t r;
        #1 check_outputs();
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            r.wr = e_issue && id_wreg && !id_md && (id_rd != '0);
            r.rd = int'(id_rd);
            r.ld = id_load;
            hist.push_front(r);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            if (e_issue && id_md) begin
                md_start = cyc;
                md_rd_m  = int'(id_rd);
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic bubble();
        set_in(0, 0, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        model_reset();
        reset = 1'b1;
        bubble();
        @(negedge clock);
        step();
        chk("rst_wpcir", 32'(o_wpcir), 32'd1);
        chk("rst_issue", 32'(o_issue), 32'd0);
        step();
        reset = 1'b0;

        // ALU result forwarded from EXE, MEM, WB, then regfile
        set_in(0, 0, 2'b00, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0); step();
        set_in(3, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); step();
        chk("alu_fwd_exe", 32'(o_fwd[1:0]), 32'd1);
        chk("alu_wpcir",   32'(o_wpcir),    32'd1);
        step(); chk("alu_fwd_mem", 32'(o_fwd[1:0]), 32'd2);
        step(); chk("alu_fwd_wb",  32'(o_fwd[1:0]), 32'd3);
        step(); chk("alu_fwd_rf",  32'(o_fwd[1:0]), 32'd0);

        // Load-use: one stall then forward from MEM
        set_in(0, 0, 2'b00, 1'b1, 5, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_in(5, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); step();
        chk("lu_wpcir", 32'(o_wpcir), 32'd0);
        chk("lu_issue", 32'(o_issue), 32'd0);
        step();
        chk("lu_fwd",   32'(o_fwd[1:0]), 32'd2);
        chk("lu_issue2", 32'(o_issue),   32'd1);

        // Youngest producer wins; r0 never forwards
        set_in(0, 0, 2'b00, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b0); step();
        set_in(0, 0, 2'b00, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b0); step();
        set_in(0, 4, 2'b11, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); step();
        chk("young_fwd1", 32'(o_fwd[3:2]), 32'd1);
        chk("r0_fwd0",    32'(o_fwd[1:0]), 32'd0);
        chk("young_wpc",  32'(o_wpcir),    32'd1);

        // Mul/div: reader of r7 stalls through the done cycle
        set_in(0, 0, 2'b00, 1'b1, 7, 1'b0, 1'b1, 1'b1, 1'b0); step();
        set_in(7, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("md_busy_k",  32'(o_busy),  32'd1);
            chk("md_stall_k", 32'(o_wpcir), 32'd0);
            chk("md_done_k",  32'(o_done),  32'(k == 4));
        end
        step();
        chk("md_rel_wpc",  32'(o_wpcir), 32'd1);
        chk("md_rel_iss",  32'(o_issue), 32'd1);
        chk("md_rel_busy", 32'(o_busy),  32'd0);

        // Second mul: blocked while busy, accepted on the done cycle
        set_in(0, 0, 2'b00, 1'b1, 8, 1'b0, 1'b1, 1'b1, 1'b0); step();
        set_in(0, 0, 2'b00, 1'b1, 9, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("md2_stall", 32'(o_wpcir), 32'd0);
        end
        step();
        chk("md2_done",  32'(o_done),  32'd1);
        chk("md2_issue", 32'(o_issue), 32'd1);
        bubble(); step();
        chk("md2_busy", 32'(o_busy), 32'd1);
        chk("md2_rd",   32'(o_mdrd), 32'd9);
        for (int k = 0; k < 5; k++) step();

        // Flush overrides a load-use stall and inserts a bubble
        set_in(0, 0, 2'b00, 1'b1, 5, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_in(5, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1); step();
        chk("fl_wpcir", 32'(o_wpcir), 32'd1);
        chk("fl_issue", 32'(o_issue), 32'd0);
        set_in(5, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); step();
        chk("fl_fwd",   32'(o_fwd[1:0]), 32'd2);
        chk("fl_iss2",  32'(o_issue),    32'd1);

        // Asynchronous reset mid-mul with a full table
        set_in(0, 0, 2'b00, 1'b1, 6, 1'b0, 1'b1, 1'b1, 1'b0); step();
        set_in(0, 0, 2'b00, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0); step();
        set_in(0, 0, 2'b00, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b0); step();
        set_in(0, 0, 2'b00, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0); step();
        set_in(3, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_outputs();
        chk("pre_rst_fwd",  32'(o_fwd[1:0]), 32'd1);
        chk("pre_rst_busy", 32'(o_busy),     32'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_wpcir", 32'(wpcir),   32'd1);
        chk("arst_issue", 32'(issue),   32'd0);
        chk("arst_fwd",   32'(fwd_sel), 32'd0);
        chk("arst_busy",  32'(md_busy), 32'd0);
        chk("arst_done",  32'(md_done), 32'd0);
        chk("arst_mdrd",  32'(md_rd),   32'd0);
        model_reset();
        @(negedge clock);
        step();
        reset = 1'b0;
        bubble();
        for (int k = 0; k < 6; k++) step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            set_in(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   2'($urandom), $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 7)), r < 3, r == 9,
                   $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
